sum_frame_tx: RTL

// - Serial transmitter for the adder datapath.
// - Accepts two 8-bit operands through a valid/ready handshake and forms the 9-bit sum {carry, sum[7:0]}.
// - Shifts the sum out on one pin as a framed word: start, 9 data bits LSB-first, optional parity, stop.
// - Sits between the user input pins and one dedicated output; a matching receiver on the board captures the frame.

---
 rtl/sum_tx_pkg.sv | 31 +++
 rtl/baud_tick_gen.sv | 36 +++
 rtl/sum_frame_tx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sum_tx_pkg.sv
// Shared definitions for the sum_frame_tx serial transmitter.
// Holds the FSM state encoding, the default frame geometry, the idle
// line level and a small helper for sizing counters.
package sum_tx_pkg;

  // Transmit FSM states. ST_PARITY is only reachable when the
  // SUM_TX_PARITY_EN build option is enabled.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int DATA_W_DEF       = 8;
  localparam int CLKS_PER_BIT_DEF = 4;

  // The data field carries the full sum, including the carry out.
  localparam int FRAME_DATA_BITS = DATA_W_DEF + 1;

  // The serial line rests high between frames and during the stop bit.
  localparam logic TX_IDLE_LVL = 1'b1;

  // Width needed to count 0..n-1, never less than one bit so that a
  // single-value counter still has a legal declaration.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer for sum_frame_tx.
// Counts 0..CLKS_PER_BIT-1 and wraps; tick_o is high during the last
// cycle of every bit period. clear_i restarts the period so the first
// bit of a frame (the start bit) lasts exactly CLKS_PER_BIT cycles.
module baud_tick_gen
  import sum_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Free-running bit-period counter, restarted by clear_i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/sum_frame_tx.sv
// Serial transmitter for the adder datapath.
// Accepts two DATA_W-bit operands over a valid/ready handshake, forms the
// DATA_W+1 bit sum (carry included) and shifts it out on tx as a frame:
// start bit (0), DATA_W+1 data bits LSB-first, optional even parity bit,
// stop bit (1). Each bit lasts CLKS_PER_BIT clock cycles.
// Build option: define SUM_TX_PARITY_EN to insert the parity bit after
// the data bits; when undefined the data bits go straight to the stop bit.
module sum_frame_tx
  import sum_tx_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int NBITS     = DATA_W + 1;
  localparam int BIT_CNT_W = cnt_width(NBITS);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W);

  state_t               state_q;
  logic [NBITS-1:0]     shreg_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic                 tx_q;
  logic                 in_ready_q;
  logic                 busy_q;
  logic                 done_q;
`ifdef SUM_TX_PARITY_EN
  logic                 parity_q;
`endif

  logic [NBITS-1:0] sum_d;
  logic             accept;
  logic             baud_clear;
  logic             baud_tick;

  // Full-width add: zero-extend both operands so the carry lands in the
  // top bit of the data field.
  assign sum_d  = {1'b0, a} + {1'b0, b};
  assign accept = in_valid & in_ready_q;

  // The bit timer is held at zero while idle and restarted on accept, so
  // the start bit begins a fresh CLKS_PER_BIT period.
  assign baud_clear = accept | (state_q == ST_IDLE);

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear_i (baud_clear),
    .tick_o  (baud_tick)
  );

  // Frame sequencer: each bit boundary (baud tick) registers the next
  // line level into tx_q so the pin is glitch-free and changes one cycle
  // after the decision, matching the start bit falling after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= TX_IDLE_LVL;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SUM_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            shreg_q    <= sum_d;
            bit_cnt_q  <= '0;
            tx_q       <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_START;
`ifdef SUM_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
          end
        end

        ST_START: begin
          if (baud_tick) begin
            tx_q      <= shreg_q[0];
            shreg_q   <= shreg_q >> 1;
            bit_cnt_q <= '0;
            state_q   <= ST_DATA;
`ifdef SUM_TX_PARITY_EN
            parity_q  <= parity_q ^ shreg_q[0];
`endif
          end
        end

        ST_DATA: begin
          if (baud_tick) begin
            if (bit_cnt_q == LAST_BIT) begin
`ifdef SUM_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= ST_PARITY;
`else
              tx_q    <= TX_IDLE_LVL;
              state_q <= ST_STOP;
`endif
            end else begin
              tx_q      <= shreg_q[0];
              shreg_q   <= shreg_q >> 1;
              bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
`ifdef SUM_TX_PARITY_EN
              parity_q  <= parity_q ^ shreg_q[0];
`endif
            end
          end
        end

`ifdef SUM_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_tick) begin
            tx_q    <= TX_IDLE_LVL;
            state_q <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (baud_tick) begin
            tx_q       <= TX_IDLE_LVL;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end

        default: begin
          tx_q       <= TX_IDLE_LVL;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
